// File: rtl/button_event_decoder_if.sv
// Bundle between the debounce stage (master) and the gesture decoder (slave).
// Every event output is a registered pulse, high for exactly one clk cycle. No backpressure.
interface button_event_decoder_if;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       short_press;
  logic       long_press;
  logic       double_click;
  logic       held;
  logic [2:0] state;

  modport master (
    output btn_level,
    input  press_pulse, release_pulse, short_press, long_press, double_click, held, state
  );

  modport slave (
    input  btn_level,
    output press_pulse, release_pulse, short_press, long_press, double_click, held, state
  );
endinterface

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into press/release/short/long/double-click pulses.
// One shared counter times both the long-hold and the double-click gap.
module button_event_decoder #(
  parameter int LONG_TIME  = 25000000,
  parameter int DOUBLE_GAP = 12500000,
  parameter int CNT_WIDTH  = 25
) (
  input logic                  clk,
  input logic                  reset,
  button_event_decoder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    LONG_HOLD = 3'd2,
    WAIT2     = 3'd3,
    PRESS2    = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_TIME - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'(DOUBLE_GAP - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  state_t               state, state_next;
  logic [CNT_WIDTH-1:0] cnt, cnt_next;
  logic                 btn_d;
  logic                 rise, fall;
  logic                 press_d, release_d, short_d, long_d, double_d, held_d;

  assign rise = bus.btn_level & ~btn_d;
  assign fall = ~bus.btn_level & btn_d;

  // btn_d resets high so a button already held at reset must be released first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      cnt               <= '0;
      btn_d             <= 1'b1;
      bus.press_pulse   <= 1'b0;
      bus.release_pulse <= 1'b0;
      bus.short_press   <= 1'b0;
      bus.long_press    <= 1'b0;
      bus.double_click  <= 1'b0;
      bus.held          <= 1'b0;
    end else begin
      state             <= state_next;
      cnt               <= cnt_next;
      btn_d             <= bus.btn_level;
      bus.press_pulse   <= press_d;
      bus.release_pulse <= release_d;
      bus.short_press   <= short_d;
      bus.long_press    <= long_d;
      bus.double_click  <= double_d;
      bus.held          <= held_d;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (rise) begin
          state_next = PRESS1;
          cnt_next   = '0;
        end
      end
      PRESS1: begin
        // A fall on the long-press edge counts as a release.
        if (fall) begin
          state_next = WAIT2;
          cnt_next   = '0;
        end else if (cnt == LONG_LAST) begin
          state_next = LONG_HOLD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      LONG_HOLD: begin
        if (fall) begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      WAIT2: begin
        // A second press on the gap-expiry edge still makes a double click.
        if (rise) begin
          state_next = PRESS2;
          cnt_next   = '0;
        end else if (cnt == GAP_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      PRESS2: begin
        if (fall) begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    double_d  = 1'b0;
    case (state)
      IDLE:      press_d = rise;
      PRESS1: begin
        release_d = fall;
        long_d    = ~fall & (cnt == LONG_LAST);
      end
      LONG_HOLD: release_d = fall;
      WAIT2: begin
        press_d  = rise;
        double_d = rise;
        short_d  = ~rise & (cnt == GAP_LAST);
      end
      PRESS2:    release_d = fall;
      default:   ;
    endcase
    held_d = (state_next == PRESS1) || (state_next == LONG_HOLD) || (state_next == PRESS2);
  end

  assign bus.state = state;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed gesture bench: stimulus pushes time-stamped expected events, a monitor pops and compares.
module tb_button_event_decoder;
  localparam int LT = 8;
  localparam int DG = 5;
  localparam int W  = 21;

  localparam logic [4:0] EV_PRESS = 5'b10000;
  localparam logic [4:0] EV_REL   = 5'b01000;
  localparam logic [4:0] EV_SHORT = 5'b00100;
  localparam logic [4:0] EV_LONG  = 5'b00010;
  localparam logic [4:0] EV_DBL   = 5'b00001;

  logic clk;
  logic reset;
  int   cyc;
  int   n_cmp;
  int   n_fail;
  logic [W-1:0] exp_q[$];

  button_event_decoder_if bus();

  button_event_decoder #(
    .LONG_TIME (LT),
    .DOUBLE_GAP(DG),
    .CNT_WIDTH (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // driver tasks
  task automatic drive(input logic lvl);
    bus.btn_level = lvl;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_n(input logic lvl, input int n);
    for (int i = 0; i < n; i++) drive(lvl);
  endtask

  task automatic expect_ev(input int at, input logic [4:0] ev);
    logic [15:0] stamp;
    stamp = 16'(at);
    exp_q.push_back({stamp, ev});
  endtask

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [4:0]   ev;
    logic [W-1:0] got;
    logic [W-1:0] want;
    if (!reset) begin
      ev = {bus.press_pulse, bus.release_pulse, bus.short_press, bus.long_press, bus.double_click};
      if (ev != 5'b0) begin
        got = {cyc[15:0], ev};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: got ev=%b at cycle %0d, expected none", ev, cyc);
        end else begin
          want = exp_q.pop_front();
          if (got != want) begin
            n_fail++;
            $display("FAIL event: got ev=%b @%0d, expected ev=%b @%0d",
                     ev, cyc, want[4:0], want[W-1:5]);
          end
        end
      end
    end
  end

  // stimulus
  initial begin
    int t;
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b1;
    bus.btn_level = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_events", {bus.press_pulse, bus.release_pulse, bus.short_press,
                           bus.long_press, bus.double_click}, 0);
    check("reset_held", bus.held, 0);
    check("reset_state", bus.state, 0);
    drive_n(1'b0, 2);

    // short press: high 3, low
    drive(1'b1); expect_ev(cyc, EV_PRESS);
    check("short_held_rise", bus.held, 1);
    drive_n(1'b1, 2);
    drive(1'b0); t = cyc; expect_ev(t, EV_REL); expect_ev(t + DG, EV_SHORT);
    check("short_held_fall", bus.held, 0);
    check("short_state_wait2", bus.state, 3);
    drive_n(1'b0, 8);
    check("short_state_idle", bus.state, 0);

    // long press: high 20
    drive(1'b1); t = cyc; expect_ev(t, EV_PRESS); expect_ev(t + LT, EV_LONG);
    for (int i = 0; i < 19; i++) begin
      drive(1'b1);
      if (i == 6 || i == 18) check("long_held", bus.held, 1);
    end
    check("long_state", bus.state, 2);
    drive(1'b0); expect_ev(cyc, EV_REL);
    check("long_held_off", bus.held, 0);
    drive_n(1'b0, 8);

    // double click: high 2, low 3, high 2, low
    drive(1'b1); expect_ev(cyc, EV_PRESS);
    drive(1'b1);
    drive(1'b0); expect_ev(cyc, EV_REL);
    drive_n(1'b0, 2);
    drive(1'b1); expect_ev(cyc, EV_PRESS | EV_DBL);
    check("dbl_state", bus.state, 4);
    drive(1'b1);
    check("dbl_held", bus.held, 1);
    drive(1'b0); expect_ev(cyc, EV_REL);
    check("dbl_held_off", bus.held, 0);
    drive_n(1'b0, 8);

    // gap boundary: rise sampled 5 cycles after release -> double click
    drive(1'b1); expect_ev(cyc, EV_PRESS);
    drive(1'b0); expect_ev(cyc, EV_REL);
    drive_n(1'b0, DG - 1);
    drive(1'b1); expect_ev(cyc, EV_PRESS | EV_DBL);
    drive(1'b0); expect_ev(cyc, EV_REL);
    drive_n(1'b0, 8);

    // gap variant: rise at 6 cycles -> short press, then fresh press from idle
    drive(1'b1); expect_ev(cyc, EV_PRESS);
    drive(1'b0); t = cyc; expect_ev(t, EV_REL); expect_ev(t + DG, EV_SHORT);
    drive_n(1'b0, DG);
    drive(1'b1); expect_ev(cyc, EV_PRESS);
    check("gap6_state", bus.state, 1);
    drive(1'b0); t = cyc; expect_ev(t, EV_REL); expect_ev(t + DG, EV_SHORT);
    drive_n(1'b0, 8);

    // long boundary: fall sampled at the 8th held edge
    drive(1'b1); expect_ev(cyc, EV_PRESS);
    drive_n(1'b1, LT - 1);
    drive(1'b0); t = cyc; expect_ev(t, EV_REL); expect_ev(t + DG, EV_SHORT);
    check("lbound_state", bus.state, 3);
    drive_n(1'b0, 8);

    // reset mid-gesture in WAIT2 with the button held high
    drive(1'b1); expect_ev(cyc, EV_PRESS);
    drive(1'b0); expect_ev(cyc, EV_REL);
    drive(1'b0);
    bus.btn_level = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_mid_events", {bus.press_pulse, bus.release_pulse, bus.short_press,
                             bus.long_press, bus.double_click}, 0);
    check("rst_mid_held", bus.held, 0);
    check("rst_mid_state", bus.state, 0);
    drive_n(1'b1, 8);
    check("rst_hold_state", bus.state, 0);
    drive(1'b0);
    drive(1'b1); expect_ev(cyc, EV_PRESS);
    drive(1'b0); t = cyc; expect_ev(t, EV_REL); expect_ev(t + DG, EV_SHORT);
    drive_n(1'b0, 8);

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
